// File: rtl/p1v_reset_sequencer.sv
// p1v_reset_sequencer
// -------------------
// Owns the reset of the p1v core. The host RTS line, the board reset button
// and the clock-generator lock are merged into one registered, active-low
// core reset with a guaranteed minimum hold time. The block also records the
// cause of the last reset and counts how often a running core was reset.
//
// Ports:
//   clock_160   in   system clock, the only clock of the block
//   res         in   synchronous active-high block reset
//   locked      in   clock generator locked (asynchronous, synchronized here)
//   rts         in   host RTS line, active-low (asynchronous)
//   btn_n       in   board reset button, active-low, bouncy (asynchronous)
//   resn        out  registered active-low reset to p1v (inp_resn)
//   res_active  out  high whenever resn is low (status LED)
//   reset_cause out  last cause: 0 power-on/res, 1 rts, 2 button, 3 lock loss
//   reset_count out  resets of a running core, saturating at 255

module p1v_reset_sequencer #(
    parameter int HOLD_CYCLES     = 16000,
    parameter int DEBOUNCE_CYCLES = 1600000,
    parameter int CNT_W           = 24
) (
    input  logic       clock_160,
    input  logic       res,
    input  logic       locked,
    input  logic       rts,
    input  logic       btn_n,
    output logic       resn,
    output logic       res_active,
    output logic [1:0] reset_cause,
    output logic [7:0] reset_count
);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_ASSERT    = 2'd1;
    localparam logic [1:0] ST_HOLD      = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    localparam logic [1:0] CAUSE_RTS  = 2'd1;
    localparam logic [1:0] CAUSE_BTN  = 2'd2;
    localparam logic [1:0] CAUSE_LOCK = 2'd3;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             rts_m, rts_s;
    logic             btn_m, btn_s;
    logic             lock_m, lock_s;
    logic             btn_db;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_next;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             lock_ok;
    logic             src_asserted;
    logic             leaving_active;
    logic             leaving_run;
    logic [1:0]       cause_next;

    // Two-flop synchronizers. RTS and button idle high so a reset of the
    // block never looks like a request; lock idles low so no hold can start
    // before the clock generator is seen locked.
    always_ff @(posedge clock_160) begin
        if (res) begin
            rts_m  <= 1'b1;
            rts_s  <= 1'b1;
            btn_m  <= 1'b1;
            btn_s  <= 1'b1;
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            rts_m  <= rts;
            rts_s  <= rts_m;
            btn_m  <= btn_n;
            btn_s  <= btn_m;
            lock_m <= locked;
            lock_s <= lock_m;
        end
    end

    // Button debounce: the counter only runs while the synced button differs
    // from the debounced value, so any return to agreement throws away the
    // partial count and short bounces never reach the toggle point.
    always_ff @(posedge clock_160) begin
        if (res) begin
            btn_db <= 1'b1;
            db_cnt <= '0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db <= ~btn_db;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign lock_ok      = lock_s;
    assign src_asserted = ~rts_s | ~btn_db;

    // Next-state logic. Lock loss always wins, then an asserted source, then
    // the hold countdown. Every entry into HOLD reloads the full hold time.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        case (state)
            ST_WAIT_LOCK: begin
                if (lock_ok) begin
                    if (src_asserted) begin
                        state_next = ST_ASSERT;
                    end else begin
                        state_next = ST_HOLD;
                        hold_next  = HOLD_LOAD;
                    end
                end
            end
            ST_ASSERT: begin
                if (!lock_ok) begin
                    state_next = ST_WAIT_LOCK;
                end else if (!src_asserted) begin
                    state_next = ST_HOLD;
                    hold_next  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (!lock_ok) begin
                    state_next = ST_WAIT_LOCK;
                end else if (src_asserted) begin
                    state_next = ST_ASSERT;
                end else if (hold_cnt == '0) begin
                    state_next = ST_RUN;
                end else begin
                    hold_next = hold_cnt - 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_ok) begin
                    state_next = ST_WAIT_LOCK;
                end else if (src_asserted) begin
                    state_next = ST_ASSERT;
                end
            end
            default: begin
                state_next = ST_WAIT_LOCK;
            end
        endcase
    end

    // The cause is only recorded when a running or releasing core is pulled
    // back into reset; lock loss dominates, then RTS, then the button.
    always_comb begin
        leaving_run    = (state == ST_RUN) &&
                         ((state_next == ST_ASSERT) || (state_next == ST_WAIT_LOCK));
        leaving_active = ((state == ST_RUN) || (state == ST_HOLD)) &&
                         ((state_next == ST_ASSERT) || (state_next == ST_WAIT_LOCK));
        if (!lock_ok) begin
            cause_next = CAUSE_LOCK;
        end else if (!rts_s) begin
            cause_next = CAUSE_RTS;
        end else begin
            cause_next = CAUSE_BTN;
        end
    end

    // State, hold counter and all outputs. resn is derived from the next
    // state so that it rises on the very edge that enters RUN and falls on
    // the edge that leaves it.
    always_ff @(posedge clock_160) begin
        if (res) begin
            state       <= ST_WAIT_LOCK;
            hold_cnt    <= '0;
            resn        <= 1'b0;
            res_active  <= 1'b1;
            reset_cause <= 2'd0;
            reset_count <= 8'd0;
        end else begin
            state      <= state_next;
            hold_cnt   <= hold_next;
            resn       <= (state_next == ST_RUN);
            res_active <= (state_next != ST_RUN);
            if (leaving_active) begin
                reset_cause <= cause_next;
            end
            if (leaving_run && (reset_count != 8'd255)) begin
                reset_count <= reset_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_p1v_reset_sequencer.sv
// tb_p1v_reset_sequencer
// ----------------------
// Self-checking bench for p1v_reset_sequencer with HOLD_CYCLES=8 and
// DEBOUNCE_CYCLES=4. A monitor records the length of every resn-low episode;
// each scenario pushes the episode length it expects into a scoreboard queue
// and pops it against the observed episode once resn returns high.

module tb_p1v_reset_sequencer;

    localparam int HOLD = 8;
    localparam int DEB  = 4;

    logic       clk;
    logic       res;
    logic       locked;
    logic       rts;
    logic       btn_n;
    logic       resn;
    logic       res_active;
    logic [1:0] reset_cause;
    logic [7:0] reset_count;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int obs_q[$];
    int low_len = 0;

    p1v_reset_sequencer #(
        .HOLD_CYCLES(HOLD),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(24)
    ) dut (
        .clock_160(clk),
        .res(res),
        .locked(locked),
        .rts(rts),
        .btn_n(btn_n),
        .resn(resn),
        .res_active(res_active),
        .reset_cause(reset_cause),
        .reset_count(reset_count)
    );

    // 100 MHz-ish bench clock; the period itself is irrelevant to the design.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Episode monitor: counts negedges with resn low and records the length
    // once resn is seen high again. A block reset restarts the count.
    always @(negedge clk) begin
        if (res) begin
            low_len = 0;
        end else if (resn === 1'b0) begin
            low_len++;
        end else if (low_len != 0) begin
            obs_q.push_back(low_len);
            low_len = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Waits (bounded) for the monitor to record a finished episode.
    task automatic wait_episode(output int len, output bit got);
        got = 1'b0;
        len = 0;
        for (int i = 0; i < 500; i++) begin
            if (obs_q.size() != 0) break;
            tick();
        end
        if (obs_q.size() != 0) begin
            len = obs_q.pop_front();
            got = 1'b1;
        end
    endtask

    task automatic test_reset();
        int len;
        int exp;
        bit got;
        $display("[TB] test_reset");
        res = 1'b1; locked = 1'b1; rts = 1'b1; btn_n = 1'b1;
        ticks(2);
        checks++; if (resn !== 1'b0) begin errors++; $display("[TB] FAIL reset_resn: got %0d, expected 0", resn); end
        checks++; if (res_active !== 1'b1) begin errors++; $display("[TB] FAIL reset_res_active: got %0d, expected 1", res_active); end
        checks++; if (reset_cause !== 2'd0) begin errors++; $display("[TB] FAIL reset_cause: got %0d, expected 0", reset_cause); end
        checks++; if (reset_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d, expected 0", reset_count); end
        res = 1'b0;
        // 2 lock sync edges + 8 hold edges keep resn low, the 11th edge enters RUN
        exp_q.push_back(HOLD + 3);
        for (int i = 1; i <= HOLD + 2; i++) begin
            tick();
            checks++; if (resn !== 1'b0) begin errors++; $display("[TB] FAIL poweron_low_%0d: got %0d, expected 0", i, resn); end
        end
        tick();
        checks++; if (resn !== 1'b1) begin errors++; $display("[TB] FAIL poweron_release: got %0d, expected 1", resn); end
        checks++; if (res_active !== 1'b0) begin errors++; $display("[TB] FAIL poweron_res_active: got %0d, expected 0", res_active); end
        wait_episode(len, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got) begin errors++; $display("[TB] FAIL poweron_episode: got timeout, expected %0d", exp); end
        else if (len !== exp) begin errors++; $display("[TB] FAIL poweron_episode: got %0d, expected %0d", len, exp); end
        checks++; if (reset_cause !== 2'd0) begin errors++; $display("[TB] FAIL poweron_cause: got %0d, expected 0", reset_cause); end
        checks++; if (reset_count !== 8'd0) begin errors++; $display("[TB] FAIL poweron_count: got %0d, expected 0", reset_count); end
    endtask

    task automatic test_rts();
        int len;
        int exp;
        bit got;
        $display("[TB] test_rts");
        exp_q.push_back(5 + HOLD);
        rts = 1'b0;
        ticks(2);
        checks++; if (resn !== 1'b1) begin errors++; $display("[TB] FAIL rts_latency_early: got %0d, expected 1", resn); end
        tick();
        checks++; if (resn !== 1'b0) begin errors++; $display("[TB] FAIL rts_latency_3rd_edge: got %0d, expected 0", resn); end
        checks++; if (res_active !== 1'b1) begin errors++; $display("[TB] FAIL rts_res_active: got %0d, expected 1", res_active); end
        ticks(2);
        rts = 1'b1;
        wait_episode(len, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got) begin errors++; $display("[TB] FAIL rts_episode: got timeout, expected %0d", exp); end
        else if (len !== exp) begin errors++; $display("[TB] FAIL rts_episode: got %0d, expected %0d", len, exp); end
        checks++; if (reset_cause !== 2'd1) begin errors++; $display("[TB] FAIL rts_cause: got %0d, expected 1", reset_cause); end
        checks++; if (reset_count !== 8'd1) begin errors++; $display("[TB] FAIL rts_count: got %0d, expected 1", reset_count); end
        ticks(3);
    endtask

    task automatic test_button();
        int len;
        int exp;
        bit got;
        $display("[TB] test_button");
        for (int i = 0; i < 20; i++) begin
            btn_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            checks++; if (resn !== 1'b1) begin errors++; $display("[TB] FAIL bounce_resn_%0d: got %0d, expected 1", i, resn); end
        end
        btn_n = 1'b1;
        ticks(8);
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL bounce_no_episode: got %0d episodes, expected 0", obs_q.size()); end
        checks++; if (resn !== 1'b1) begin errors++; $display("[TB] FAIL bounce_settled: got %0d, expected 1", resn); end
        // 2 sync edges + 4 debounce edges + 1 state edge
        exp_q.push_back(10 + HOLD);
        btn_n = 1'b0;
        ticks(6);
        checks++; if (resn !== 1'b1) begin errors++; $display("[TB] FAIL btn_latency_early: got %0d, expected 1", resn); end
        tick();
        checks++; if (resn !== 1'b0) begin errors++; $display("[TB] FAIL btn_latency_7th_edge: got %0d, expected 0", resn); end
        ticks(3);
        btn_n = 1'b1;
        wait_episode(len, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got) begin errors++; $display("[TB] FAIL btn_episode: got timeout, expected %0d", exp); end
        else if (len !== exp) begin errors++; $display("[TB] FAIL btn_episode: got %0d, expected %0d", len, exp); end
        checks++; if (reset_cause !== 2'd2) begin errors++; $display("[TB] FAIL btn_cause: got %0d, expected 2", reset_cause); end
        checks++; if (reset_count !== 8'd2) begin errors++; $display("[TB] FAIL btn_count: got %0d, expected 2", reset_count); end
        ticks(3);
    endtask

    task automatic test_retrigger();
        int len;
        int exp;
        bit got;
        $display("[TB] test_retrigger");
        // ASSERT from edge 3, HOLD on edges 6..10, rts seen again on edge 11,
        // released so HOLD restarts on edge 15 and RUN arrives on edge 23.
        exp_q.push_back(20);
        rts = 1'b0;
        ticks(3);
        rts = 1'b1;
        ticks(5);
        rts = 1'b0;
        ticks(4);
        rts = 1'b1;
        checks++; if (resn !== 1'b0) begin errors++; $display("[TB] FAIL retrig_still_low: got %0d, expected 0", resn); end
        wait_episode(len, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got) begin errors++; $display("[TB] FAIL retrig_episode: got timeout, expected %0d", exp); end
        else if (len !== exp) begin errors++; $display("[TB] FAIL retrig_episode: got %0d, expected %0d", len, exp); end
        checks++; if (reset_cause !== 2'd1) begin errors++; $display("[TB] FAIL retrig_cause: got %0d, expected 1", reset_cause); end
        checks++; if (reset_count !== 8'd3) begin errors++; $display("[TB] FAIL retrig_count: got %0d, expected 3", reset_count); end
        ticks(3);
    endtask

    task automatic test_lock_loss();
        int len;
        int exp;
        bit got;
        $display("[TB] test_lock_loss");
        // WAIT_LOCK on edge 3, ASSERT on edge 8 after relock, HOLD on 13..20
        exp_q.push_back(18);
        rts = 1'b0;
        locked = 1'b0;
        ticks(2);
        checks++; if (resn !== 1'b1) begin errors++; $display("[TB] FAIL lock_latency_early: got %0d, expected 1", resn); end
        tick();
        checks++; if (resn !== 1'b0) begin errors++; $display("[TB] FAIL lock_latency_3rd_edge: got %0d, expected 0", resn); end
        ticks(2);
        checks++; if (reset_cause !== 2'd3) begin errors++; $display("[TB] FAIL lock_cause: got %0d, expected 3", reset_cause); end
        checks++; if (reset_count !== 8'd4) begin errors++; $display("[TB] FAIL lock_count: got %0d, expected 4", reset_count); end
        locked = 1'b1;
        ticks(5);
        rts = 1'b1;
        checks++; if (reset_cause !== 2'd3) begin errors++; $display("[TB] FAIL relock_cause: got %0d, expected 3", reset_cause); end
        wait_episode(len, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got) begin errors++; $display("[TB] FAIL lock_episode: got timeout, expected %0d", exp); end
        else if (len !== exp) begin errors++; $display("[TB] FAIL lock_episode: got %0d, expected %0d", len, exp); end
        checks++; if (reset_count !== 8'd4) begin errors++; $display("[TB] FAIL relock_count: got %0d, expected 4", reset_count); end
        ticks(3);
    endtask

    task automatic test_saturation();
        int len;
        int exp;
        bit got;
        $display("[TB] test_saturation");
        for (int i = 1; i <= 300; i++) begin
            exp_q.push_back(2 + HOLD);
            rts = 1'b0;
            ticks(2);
            rts = 1'b1;
            wait_episode(len, got);
            exp = exp_q.pop_front();
            checks++;
            if (!got) begin errors++; $display("[TB] FAIL sat_episode_%0d: got timeout, expected %0d", i, exp); end
            else if (len !== exp) begin errors++; $display("[TB] FAIL sat_episode_%0d: got %0d, expected %0d", i, len, exp); end
            if (i == 250) begin
                checks++; if (reset_count !== 8'd254) begin errors++; $display("[TB] FAIL sat_count_254: got %0d, expected 254", reset_count); end
            end
            if (i == 251) begin
                checks++; if (reset_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_count_255: got %0d, expected 255", reset_count); end
            end
            tick();
        end
        checks++; if (reset_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_count_hold: got %0d, expected 255", reset_count); end
    endtask

    task automatic test_mid_reset();
        int len;
        int exp;
        bit got;
        $display("[TB] test_mid_reset");
        rts = 1'b0;
        ticks(2);
        rts = 1'b1;
        ticks(5);
        checks++; if (resn !== 1'b0) begin errors++; $display("[TB] FAIL midres_in_hold: got %0d, expected 0", resn); end
        checks++; if (reset_cause !== 2'd1) begin errors++; $display("[TB] FAIL midres_cause_before: got %0d, expected 1", reset_cause); end
        res = 1'b1;
        tick();
        checks++; if (resn !== 1'b0) begin errors++; $display("[TB] FAIL midres_resn: got %0d, expected 0", resn); end
        checks++; if (res_active !== 1'b1) begin errors++; $display("[TB] FAIL midres_res_active: got %0d, expected 1", res_active); end
        checks++; if (reset_cause !== 2'd0) begin errors++; $display("[TB] FAIL midres_cause: got %0d, expected 0", reset_cause); end
        checks++; if (reset_count !== 8'd0) begin errors++; $display("[TB] FAIL midres_count: got %0d, expected 0", reset_count); end
        res = 1'b0;
        exp_q.push_back(HOLD + 3);
        wait_episode(len, got);
        exp = exp_q.pop_front();
        checks++;
        if (!got) begin errors++; $display("[TB] FAIL midres_episode: got timeout, expected %0d", exp); end
        else if (len !== exp) begin errors++; $display("[TB] FAIL midres_episode: got %0d, expected %0d", len, exp); end
        checks++; if (reset_count !== 8'd0) begin errors++; $display("[TB] FAIL midres_count_after: got %0d, expected 0", reset_count); end
    endtask

    initial begin
        res = 1'b1; locked = 1'b1; rts = 1'b1; btn_n = 1'b1;
        test_reset();
        ticks(3);
        test_rts();
        test_button();
        test_retrigger();
        test_lock_loss();
        test_saturation();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
